// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl
// Purpose  : Issue, hazard and writeback control for the pipelined divider.
// Revision : 1.0  initial release
// ============================================================================
module div_issue_ctrl #(
    parameter int DIV_LAT      = 8,
    parameter int BUF_DEPTH    = 2,
    parameter int SINGLE_ISSUE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic        id_rs1_used,
    input  logic [4:0]  id_rs1_addr,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_rd_we,
    input  logic [4:0]  id_rd_addr,
    input  logic        ex_div_req,
    input  logic        ex_div_sign,
    input  logic        ex_div_rem,
    input  logic [4:0]  ex_rd_addr,
    input  logic [31:0] div_res_i,
    input  logic        pipe_wb_we,
    output logic        div_use,
    output logic        div_sign,
    output logic        div_rem,
    output logic        stall,
    output logic        rf_div_we,
    output logic [4:0]  rf_div_addr,
    output logic [31:0] rf_div_data,
    output logic        busy
);

    localparam int c_PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int c_CW = $clog2(BUF_DEPTH + 1);
    localparam int c_SW = $clog2(DIV_LAT + BUF_DEPTH + 1);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(BUF_DEPTH - 1);

    logic                r_active;
    logic [DIV_LAT-1:0]  r_vld;
    logic [4:0]          r_rd [DIV_LAT];
    logic [4:0]          r_fifo_rd   [BUF_DEPTH];
    logic [31:0]         r_fifo_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] r_fifo_vld;
    logic [c_PW-1:0]     r_head;
    logic [c_PW-1:0]     r_tail;
    logic [c_CW-1:0]     r_cnt;

    logic                w_arr_ok;
    logic [c_SW-1:0]     w_inflight;
    logic [c_SW-1:0]     w_slots;
    logic                w_busy;
    logic                w_block;
    logic                w_push;
    logic                w_pop;
    logic                w_we;
    logic [4:0]          w_addr;
    logic [31:0]         w_data;
    logic [31:0]         w_pend;
    logic                w_id_haz;

    function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PW'(1);
    endfunction

    // Outputs stay quiet for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_active <= 1'b0;
        else        r_active <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld[0] <= 1'b0;
            r_rd[0]  <= 5'd0;
        end else begin
            r_vld[0] <= div_use;
            r_rd[0]  <= ex_rd_addr;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < DIV_LAT; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld[gi] <= 1'b0;
                    r_rd[gi]  <= 5'd0;
                end else begin
                    r_vld[gi] <= r_vld[gi-1];
                    r_rd[gi]  <= r_rd[gi-1];
                end
            end
        end
    endgenerate

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < DIV_LAT; i++) begin
            w_inflight = w_inflight + c_SW'(r_vld[i]);
        end
    end

    assign w_arr_ok = r_vld[DIV_LAT-1] & (r_rd[DIV_LAT-1] != 5'd0);
    assign w_slots  = w_inflight + c_SW'(r_cnt);
    assign w_busy   = (|r_vld) | (r_cnt != '0);
    assign w_block  = (w_slots >= c_SW'(BUF_DEPTH)) | ((SINGLE_ISSUE != 0) & w_busy);

    // Main WB owns the port first; buffered results drain before direct arrivals.
    always_comb begin
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_we   = 1'b0;
        w_addr = 5'd0;
        w_data = 32'd0;
        if (pipe_wb_we) begin
            w_push = w_arr_ok;
        end else if (r_cnt != '0) begin
            w_pop  = 1'b1;
            w_push = w_arr_ok;
            w_we   = 1'b1;
            w_addr = r_fifo_rd[r_head];
            w_data = r_fifo_data[r_head];
        end else if (w_arr_ok) begin
            w_we   = 1'b1;
            w_addr = r_rd[DIV_LAT-1];
            w_data = div_res_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_cnt      <= '0;
            r_fifo_vld <= '0;
            for (int j = 0; j < BUF_DEPTH; j++) begin
                r_fifo_rd[j]   <= 5'd0;
                r_fifo_data[j] <= 32'd0;
            end
        end else begin
            if (w_pop) begin
                r_head             <= f_next(r_head);
                r_fifo_vld[r_head] <= 1'b0;
            end
            if (w_push) begin
                r_tail              <= f_next(r_tail);
                r_fifo_vld[r_tail]  <= 1'b1;
                r_fifo_rd[r_tail]   <= r_rd[DIV_LAT-1];
                r_fifo_data[r_tail] <= div_res_i;
            end
            r_cnt <= r_cnt + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    always_comb begin
        w_pend = 32'd0;
        if (ex_div_req) w_pend[ex_rd_addr] = 1'b1;
        for (int i = 0; i < DIV_LAT; i++) begin
            if (r_vld[i]) w_pend[r_rd[i]] = 1'b1;
        end
        for (int j = 0; j < BUF_DEPTH; j++) begin
            if (r_fifo_vld[j]) w_pend[r_fifo_rd[j]] = 1'b1;
        end
        if (w_we) w_pend[w_addr] = 1'b1;
        w_pend[0] = 1'b0;
    end

    assign w_id_haz = id_valid & ((id_rs1_used & w_pend[id_rs1_addr]) |
                                  (id_rs2_used & w_pend[id_rs2_addr]) |
                                  (id_rd_we    & w_pend[id_rd_addr]));

    assign div_use     = r_active & ex_div_req & ~w_block;
    assign div_sign    = div_use & ex_div_sign;
    assign div_rem     = div_use & ex_div_rem;
    assign stall       = r_active & ((ex_div_req & w_block) | w_id_haz);
    assign rf_div_we   = r_active & w_we;
    assign rf_div_addr = rf_div_we ? w_addr : 5'd0;
    assign rf_div_data = rf_div_we ? w_data : 32'd0;
    assign busy        = r_active & w_busy;

endmodule
`default_nettype wire
